stack_sequencer: RTL and testbench
==================================

STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 Timing: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  stack request present.
REQ-005 req_ready  output  1  sequencer idle; high only in IDLE.
REQ-006 req_op  input  3  0=PUSH, 1=POP, 2=CALL, 3=RET, 4=INT, 5=RTI, 6/7=invalid.
REQ-007 req_data  input  8  PUSH data, or return PC for CALL/INT.
REQ-008 req_flags  input  4  CCR flags to save on INT.
REQ-009 mem_read  output  1  DataMemory read enable.
REQ-010 mem_write  output  1  DataMemory write enable; the write commits at posedge.
REQ-011 mem_addr  output  8  DataMemory address.
REQ-012 mem_wdata  output  8  DataMemory write data.
REQ-013 mem_rdata  input  8  DataMemory read data, combinational from mem_addr.
REQ-014 rsp_valid  output  1  one-cycle completion pulse.
REQ-015 rsp_data  output  8  popped byte, return PC, or interrupt vector.
REQ-016 rsp_flags  output  4  flags restored by RTI.
REQ-017 sp  output  8  current stack pointer.
REQ-018 err_overflow, err_underflow  output  1 each  sticky stack error flags.

Function
REQ-019 Handshake: a request is accepted at a posedge where req_valid and req_ready are both high. The sequencer latches req_op, req_data and req_flags, and req_ready drops on the next cycle.
REQ-020 States are IDLE, ACC0, ACC1, ACC2 and RSP. Each ACCn state is exactly one memory-access cycle.
REQ-021 Stack convention:
- Push: M[SP] <- byte, then SP <- SP-1 at the same posedge.
- Pop: mem_addr = SP+1, then SP <- SP+1 at that posedge, with mem_rdata captured at that edge.
REQ-022 PUSH and CALL perform one push of req_data in ACC0, then go to RSP. In RSP, rsp_data = req_data.
REQ-023 POP and RET perform one pop in ACC0, then go to RSP. In RSP, rsp_data = the captured byte.
REQ-024 INT runs three access cycles, then goes to RSP with rsp_data = vector:
- ACC0: push req_data.
- ACC1: push {4'b0, req_flags}.
- ACC2: mem_read with mem_addr = 0x01; capture the vector, SP unchanged.
REQ-025 RTI runs two access cycles, then goes to RSP:
- ACC0: pop flags into rsp_flags (low 4 bits).
- ACC1: pop PC into rsp_data.
REQ-026 Invalid op goes IDLE -> RSP directly: no memory access, SP unchanged, rsp_data = 0x00.
REQ-027 RSP lasts one cycle with rsp_valid = 1, then returns to IDLE.
REQ-028 Latency, measured from the accept edge to the rsp_valid cycle:
- PUSH/POP/CALL/RET: 2 cycles.
- RTI: 3 cycles.
- INT: 4 cycles.
- invalid: 1 cycle.
REQ-029 Memory-side outputs:
- mem_read and mem_write are never both high.
- Both are 0 in IDLE and RSP.
- mem_addr and mem_wdata are 0x00 whenever neither enable is high.
REQ-030 rsp_data and rsp_flags hold their value until the next RSP.
REQ-031 Overflow: a push with SP = 0x00 still writes M[0x00], wraps SP to 0xFF, and sets err_overflow.
REQ-032 Underflow: a pop with SP = 0xFF reads M[0x00], wraps SP to 0x00, and sets err_underflow.
REQ-033 Error flags are sticky; only rst clears them.
REQ-034 req_valid while busy is ignored. Requests are never queued.

Reset
REQ-035 When rst is high at a posedge, the following hold from the next cycle:
- state IDLE; sp = 0xFF; req_ready = 1.
- rsp_valid, rsp_data, rsp_flags, mem_read, mem_write, mem_addr, mem_wdata and both error flags all 0.
REQ-036 Reset mid-operation aborts the sequence: no further memory access, and no rsp_valid for the aborted request.

Verification
REQ-037 Reset: assert rst for 2 cycles -> sp = 0xFF, req_ready = 1, all other outputs 0.
REQ-038 PUSH/POP round trip:
- PUSH req_data = 0x42 -> mem_write = 1 for one cycle, addr 0xFF, wdata 0x42; sp = 0xFE; rsp_valid 2 cycles after accept.
- Then POP -> mem_read at addr 0xFF, rsp_data = 0x42, sp = 0xFF.
REQ-039 INT/RTI round trip:
- INT with req_data = 0x37, req_flags = 0xA, mem_rdata = 0x80 at addr 0x01 -> writes 0x37@0xFF and 0x0A@0xFE, then a read at 0x01; rsp_data = 0x80, sp = 0xFD, rsp_valid 4 cycles after accept.
- Then RTI -> rsp_flags = 0xA, rsp_data = 0x37, sp = 0xFF.
REQ-040 Underflow/overflow:
- POP immediately after reset -> mem_addr = 0x00, sp = 0x00, err_underflow = 1.
- PUSH with sp = 0x00 -> write at 0x00, sp = 0xFF, err_overflow = 1; both flags stay set until rst.
REQ-041 Busy handling: hold req_valid high with PUSH 0x11, then PUSH 0x22 -> req_ready low during the first op; second write at 0xFE lands only after the first rsp_valid; sp ends at 0xFD.
REQ-042 Reset mid-INT: assert rst in ACC1 -> no write at 0xFE, no read at 0x01, no rsp_valid; sp = 0xFF next cycle.

Source files
------------

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - stack push/pop/call/interrupt sequencer over a single-port data memory
//
// Purpose: accepts one stack request at a time and runs it as a short
// sequence of data-memory accesses (one access per ACCn state), then
// reports completion with a one-cycle rsp_valid pulse.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req_valid/ready  request handshake (ready only while idle)
//   req_op           0 PUSH, 1 POP, 2 CALL, 3 RET, 4 INT, 5 RTI, 6/7 invalid
//   req_data         push byte / return PC
//   req_flags        CCR flags saved by INT
//   mem_read/write   data-memory enables (never both high)
//   mem_addr/wdata   data-memory address and write data (0 when idle)
//   mem_rdata        combinational read data for mem_addr
//   rsp_valid        one-cycle completion pulse
//   rsp_data/flags   result byte / flags restored by RTI (held until next response)
//   sp               stack pointer
//   err_overflow/underflow  sticky stack error flags
module stack_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_op,
   input  logic [7:0] req_data,
   input  logic [3:0] req_flags,
   output logic       mem_read,
   output logic       mem_write,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic [3:0] rsp_flags,
   output logic [7:0] sp,
   output logic       err_overflow,
   output logic       err_underflow
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ACC0 = 3'd1;
   localparam logic [2:0] S_ACC1 = 3'd2;
   localparam logic [2:0] S_ACC2 = 3'd3;
   localparam logic [2:0] S_RSP  = 3'd4;

   localparam logic [2:0] OP_PUSH = 3'd0;
   localparam logic [2:0] OP_POP  = 3'd1;
   localparam logic [2:0] OP_CALL = 3'd2;
   localparam logic [2:0] OP_RET  = 3'd3;
   localparam logic [2:0] OP_INT  = 3'd4;
   localparam logic [2:0] OP_RTI  = 3'd5;

   localparam logic [7:0] VEC_ADDR = 8'h01;

   logic [2:0] r_state;
   logic [2:0] r_op;
   logic [7:0] r_data;
   logic [3:0] r_flags;
   logic [7:0] r_sp;
   logic [3:0] r_cap_flags;
   logic [7:0] r_rsp_data;
   logic [3:0] r_rsp_flags;
   logic       r_ovf;
   logic       r_udf;

   logic [2:0] w_next_state;
   logic       w_accept;
   logic       w_push;
   logic       w_pop;
   logic       w_vec;
   logic [7:0] w_push_byte;
   logic       w_load_rsp;
   logic [7:0] w_rsp_data_nxt;
   logic       w_load_flags;
   logic       w_wr_en;
   logic       w_rd_en;

   assign w_accept = (r_state == S_IDLE) && req_valid;

   always_comb begin
      w_next_state   = r_state;
      w_push         = 1'b0;
      w_pop          = 1'b0;
      w_vec          = 1'b0;
      w_push_byte    = r_data;
      w_load_rsp     = 1'b0;
      w_rsp_data_nxt = r_rsp_data;
      w_load_flags   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (req_op > OP_RTI) begin
                  w_next_state   = S_RSP;
                  w_load_rsp     = 1'b1;
                  w_rsp_data_nxt = 8'h00;
               end else begin
                  w_next_state = S_ACC0;
               end
            end
         end
         S_ACC0: begin
            case (r_op)
               OP_PUSH, OP_CALL: begin
                  w_push         = 1'b1;
                  w_next_state   = S_RSP;
                  w_load_rsp     = 1'b1;
                  w_rsp_data_nxt = r_data;
               end
               OP_POP, OP_RET: begin
                  w_pop          = 1'b1;
                  w_next_state   = S_RSP;
                  w_load_rsp     = 1'b1;
                  w_rsp_data_nxt = mem_rdata;
               end
               OP_INT: begin
                  w_push       = 1'b1;
                  w_next_state = S_ACC1;
               end
               OP_RTI: begin
                  // flags byte is parked in r_cap_flags so rsp_flags only moves on entry to RSP
                  w_pop        = 1'b1;
                  w_next_state = S_ACC1;
               end
               default: begin
                  w_next_state   = S_RSP;
                  w_load_rsp     = 1'b1;
                  w_rsp_data_nxt = 8'h00;
               end
            endcase
         end
         S_ACC1: begin
            if (r_op == OP_INT) begin
               w_push       = 1'b1;
               w_push_byte  = {4'h0, r_flags};
               w_next_state = S_ACC2;
            end else if (r_op == OP_RTI) begin
               w_pop          = 1'b1;
               w_next_state   = S_RSP;
               w_load_rsp     = 1'b1;
               w_rsp_data_nxt = mem_rdata;
               w_load_flags   = 1'b1;
            end else begin
               w_next_state   = S_RSP;
               w_load_rsp     = 1'b1;
               w_rsp_data_nxt = 8'h00;
            end
         end
         S_ACC2: begin
            w_vec          = 1'b1;
            w_next_state   = S_RSP;
            w_load_rsp     = 1'b1;
            w_rsp_data_nxt = mem_rdata;
         end
         S_RSP: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Enables are masked by rst so an access in the cycle that reset lands
   // never commits into memory; the aborted sequence leaves no trace.
   assign w_wr_en = w_push && !rst;
   assign w_rd_en = (w_pop || w_vec) && !rst;

   assign mem_write = w_wr_en;
   assign mem_read  = w_rd_en;
   assign mem_addr  = w_wr_en ? r_sp :
                      (w_rd_en && w_pop) ? (r_sp + 8'd1) :
                      w_rd_en ? VEC_ADDR : 8'h00;
   assign mem_wdata = w_wr_en ? w_push_byte : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_op        <= 3'd0;
         r_data      <= 8'h00;
         r_flags     <= 4'h0;
         r_sp        <= 8'hFF;
         r_cap_flags <= 4'h0;
         r_rsp_data  <= 8'h00;
         r_rsp_flags <= 4'h0;
         r_ovf       <= 1'b0;
         r_udf       <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_op    <= req_op;
            r_data  <= req_data;
            r_flags <= req_flags;
         end
         // SP wraps naturally in 8 bits; the wrap itself is what flags the error
         if (w_push) begin
            r_sp <= r_sp - 8'd1;
            if (r_sp == 8'h00) begin
               r_ovf <= 1'b1;
            end
         end else if (w_pop) begin
            r_sp <= r_sp + 8'd1;
            if (r_sp == 8'hFF) begin
               r_udf <= 1'b1;
            end
         end
         if (r_state == S_ACC0 && r_op == OP_RTI) begin
            r_cap_flags <= mem_rdata[3:0];
         end
         if (w_load_rsp) begin
            r_rsp_data <= w_rsp_data_nxt;
         end
         if (w_load_flags) begin
            r_rsp_flags <= r_cap_flags;
         end
      end
   end

   assign req_ready     = (r_state == S_IDLE);
   assign rsp_valid     = (r_state == S_RSP);
   assign rsp_data      = r_rsp_data;
   assign rsp_flags     = r_rsp_flags;
   assign sp            = r_sp;
   assign err_overflow  = r_ovf;
   assign err_underflow = r_udf;

endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - scoreboard bench for stack_sequencer with a behavioural stack model
module tb_stack_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_op;
   logic [7:0] req_data;
   logic [3:0] req_flags;
   logic       mem_read;
   logic       mem_write;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic [3:0] rsp_flags;
   logic [7:0] sp;
   logic       err_overflow;
   logic       err_underflow;

   always #5 clk = ~clk;

   stack_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_data      (req_data),
      .req_flags     (req_flags),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .rsp_flags     (rsp_flags),
      .sp            (sp),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // data memory seen by the DUT; pokes preload it
   logic [7:0] tb_mem [256];
   logic       poke_en;
   logic [7:0] poke_addr;
   logic [7:0] poke_data;

   always @(posedge clk) begin
      if (poke_en) tb_mem[poke_addr] <= poke_data;
      else if (mem_write) tb_mem[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = tb_mem[mem_addr];

   typedef struct {
      logic [7:0] data;
      bit         chk_flags;
      logic [3:0] flags;
      logic [7:0] sp;
      bit         ovf;
      bit         udf;
      int         acc;
      int         lat;
   } exp_t;

   exp_t exp_q[$];

   // reference stack model
   logic [7:0] ref_mem [256];
   logic [7:0] m_sp;
   bit         m_ovf;
   bit         m_udf;
   logic [7:0] last_exp_data;
   int         last_rsp_cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: bound expired at cycle %0d", name, cyc);
   endtask

   function automatic void m_push(input logic [7:0] b);
      ref_mem[m_sp] = b;
      if (m_sp == 8'h00) m_ovf = 1'b1;
      m_sp = m_sp - 8'd1;
   endfunction

   function automatic logic [7:0] m_pop();
      if (m_sp == 8'hFF) m_udf = 1'b1;
      m_sp = m_sp + 8'd1;
      return ref_mem[m_sp];
   endfunction

   // monitor: pops the scoreboard whenever the DUT responds
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         check("mem_exclusive", {mem_read, mem_write} == 2'b11, 1'b0);
         if (!mem_read && !mem_write) check("mem_idle_zero", {mem_addr, mem_wdata}, 16'h0);
         if (rsp_valid || req_ready) check("mem_off_idle_rsp", {mem_read, mem_write}, 2'b00);
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_data", rsp_data, e.data);
               if (e.chk_flags) check("rsp_flags", rsp_flags, e.flags);
               check("rsp_sp", sp, e.sp);
               check("rsp_err_flags", {err_overflow, err_underflow}, {e.ovf, e.udf});
               check("latency", cyc - e.acc, e.lat);
            end
            last_rsp_cyc = cyc;
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [7:0] d, input logic [3:0] f,
                        input bit expect_rsp, input bit hold, output int acc);
      exp_t e;
      int   t;
      @(posedge clk); #1;
      req_op    = op;
      req_data  = d;
      req_flags = f;
      req_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!req_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      acc = cyc;
      if (!req_ready) begin
         fail_now("accept_timeout");
         req_valid = 1'b0;
         return;
      end
      if (expect_rsp) begin
         e.chk_flags = 1'b0;
         e.flags     = 4'h0;
         case (op)
            3'd0, 3'd2: begin m_push(d); e.data = d; e.lat = 2; end
            3'd1, 3'd3: begin e.data = m_pop(); e.lat = 2; end
            3'd4: begin
               m_push(d);
               m_push({4'h0, f});
               e.data = ref_mem[1];
               e.lat  = 4;
            end
            3'd5: begin
               logic [7:0] fl;
               fl          = m_pop();
               e.data      = m_pop();
               e.flags     = fl[3:0];
               e.chk_flags = 1'b1;
               e.lat       = 3;
            end
            default: begin e.data = 8'h00; e.lat = 1; end
         endcase
         e.sp  = m_sp;
         e.ovf = m_ovf;
         e.udf = m_udf;
         e.acc = acc;
         last_exp_data = e.data;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((exp_q.size() != 0 || !req_ready) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) fail_now("idle_timeout");
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst   = 1'b0;
      m_sp  = 8'hFF;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      exp_q.delete();
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      poke_en   = 1'b1;
      poke_addr = a;
      poke_data = d;
      ref_mem[a] = d;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int acc;
      int acc1;
      int rsp1;
      int nmis;
      logic [7:0] snap;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = 3'd0;
      req_data  = 8'h00;
      req_flags = 4'h0;
      poke_en   = 1'b0;
      poke_addr = 8'h00;
      poke_data = 8'h00;
      for (int i = 0; i < 256; i++) poke(i[7:0], 8'($urandom));
      do_reset();

      // reset state
      check("reset_outputs",
            {req_ready, rsp_valid, rsp_data, rsp_flags, mem_read, mem_write,
             mem_addr, mem_wdata, err_overflow, err_underflow, sp},
            {1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF});

      // PUSH/POP round trip
      issue(3'd0, 8'h42, 4'h0, 1'b1, 1'b0, acc);
      wait_idle();
      check("push_mem_ff", tb_mem[8'hFF], 8'h42);
      issue(3'd1, 8'h00, 4'h0, 1'b1, 1'b0, acc);
      wait_idle();

      // INT/RTI round trip with vector 0x80
      poke(8'h01, 8'h80);
      issue(3'd4, 8'h37, 4'hA, 1'b1, 1'b0, acc);
      wait_idle();
      check("int_mem_ff", tb_mem[8'hFF], 8'h37);
      check("int_mem_fe", tb_mem[8'hFE], 8'h0A);
      issue(3'd5, 8'h00, 4'h0, 1'b1, 1'b0, acc);
      wait_idle();

      // invalid op
      issue(3'd6, 8'hAB, 4'h0, 1'b1, 1'b0, acc);
      wait_idle();

      // underflow then overflow
      do_reset();
      issue(3'd1, 8'h00, 4'h0, 1'b1, 1'b0, acc);
      wait_idle();
      issue(3'd0, 8'h5A, 4'h0, 1'b1, 1'b0, acc);
      wait_idle();
      check("ovf_mem_00", tb_mem[8'h00], 8'h5A);
      issue(3'd2, 8'h66, 4'h0, 1'b1, 1'b0, acc);
      wait_idle();
      check("sticky_flags", {err_overflow, err_underflow}, 2'b11);

      // busy handling: valid held high across two PUSHes
      do_reset();
      issue(3'd0, 8'h11, 4'h0, 1'b1, 1'b1, acc1);
      check("busy_ready_low", req_ready, 1'b0);
      issue(3'd0, 8'h22, 4'h0, 1'b1, 1'b0, acc);
      rsp1 = last_rsp_cyc;
      check("busy_second_after_rsp", (acc > rsp1) && (rsp1 > acc1), 1'b1);
      wait_idle();
      check("busy_sp", sp, 8'hFD);
      check("busy_mem_fe", tb_mem[8'hFE], 8'h22);

      // reset in ACC1 of INT
      do_reset();
      snap = tb_mem[8'hFE];
      issue(3'd4, 8'h99, 4'h3, 1'b0, 1'b0, acc);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midint_no_access", {mem_read, mem_write}, 2'b00);
      @(posedge clk); #1;
      rst = 1'b0;
      ref_mem[8'hFF] = 8'h99;
      m_sp  = 8'hFF;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      check("midint_sp", sp, 8'hFF);
      repeat (6) @(negedge clk);
      check("midint_no_write_fe", tb_mem[8'hFE], snap);
      check("midint_ready", req_ready, 1'b1);

      // randomized traffic
      for (int n = 0; n < 80; n++) begin
         issue(3'($urandom_range(0, 7)), 8'($urandom), 4'($urandom), 1'b1, 1'b0, acc);
         wait_idle();
         repeat ($urandom_range(0, 3)) @(negedge clk);
         check("rsp_hold", rsp_data, last_exp_data);
      end

      wait_idle();
      nmis = 0;
      for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) nmis++;
      check("mem_image_mismatches", nmis, 0);
      check("final_sp", sp, m_sp);
      check("final_err_flags", {err_overflow, err_underflow}, {m_ovf, m_udf});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
